// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues I-cache reads and loads the IF/ID register.
// Handles miss latency, decode back-pressure via a one-entry buffer, redirects and HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800,
    parameter logic [4:0]  HALT_OPC = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    input  logic        icache_stall,
    input  logic        icache_done,
    input  logic [15:0] icache_data,
    output logic        icache_rd,
    output logic [15:0] icache_addr,
    output logic [15:0] fetch_pc,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        halt_fetched
);

    typedef enum logic [2:0] {FETCH, WAIT, HOLD, SQUASH, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] buf_inst;
    logic [15:0] buf_pc2;
    logic [15:0] pc_plus2;
    logic        complete;
    logic        data_is_halt;
    logic        buf_is_halt;
    logic        outstanding;

    assign pc_plus2     = pc + 16'd2;
    assign icache_rd    = (state == FETCH) && !icache_stall && !rst;
    assign icache_addr  = pc;
    assign fetch_pc     = pc;
    assign complete     = (icache_rd && icache_done) || ((state == WAIT) && icache_done);
    assign data_is_halt = (icache_data[15:11] == HALT_OPC);
    assign buf_is_halt  = (buf_inst[15:11] == HALT_OPC);
    // A request still awaits its response after this edge.
    assign outstanding  = ((state == WAIT) || (state == SQUASH) || icache_rd) && !icache_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            buf_inst     <= NOP_INST;
            buf_pc2      <= RESET_PC;
            if_id_inst   <= NOP_INST;
            if_id_pc2    <= RESET_PC;
            if_id_valid  <= 1'b0;
            halt_fetched <= 1'b0;
        end else if (redirect_en) begin
            pc           <= redirect_pc;
            buf_inst     <= NOP_INST;
            if_id_inst   <= NOP_INST;
            if_id_valid  <= 1'b0;
            halt_fetched <= 1'b0;
            state        <= outstanding ? SQUASH : FETCH;
        end else if (complete) begin
            // HALT keeps the PC pointing at itself.
            if (!data_is_halt) begin
                pc <= pc_plus2;
            end
            if (!dec_stall) begin
                if_id_inst   <= icache_data;
                if_id_pc2    <= pc_plus2;
                if_id_valid  <= 1'b1;
                halt_fetched <= data_is_halt;
                state        <= data_is_halt ? HALTED : FETCH;
            end else begin
                buf_inst <= icache_data;
                buf_pc2  <= pc_plus2;
                state    <= HOLD;
            end
        end else if ((state == HOLD) && !dec_stall) begin
            if_id_inst   <= buf_inst;
            if_id_pc2    <= buf_pc2;
            if_id_valid  <= 1'b1;
            halt_fetched <= buf_is_halt;
            state        <= buf_is_halt ? HALTED : FETCH;
        end else begin
            if (!dec_stall) begin
                if_id_inst  <= NOP_INST;
                if_id_valid <= 1'b0;
            end
            case (state)
                FETCH:   if (icache_rd) state <= WAIT;
                SQUASH:  if (icache_done) state <= FETCH;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each vector applies one cycle of inputs and
// checks the request outputs before the edge and the IF/ID/PC state after it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        icache_stall;
    logic        icache_done;
    logic [15:0] icache_data;
    logic        icache_rd;
    logic [15:0] icache_addr;
    logic [15:0] fetch_pc;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        halt_fetched;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .dec_stall    (dec_stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .icache_stall (icache_stall),
        .icache_done  (icache_done),
        .icache_data  (icache_data),
        .icache_rd    (icache_rd),
        .icache_addr  (icache_addr),
        .fetch_pc     (fetch_pc),
        .if_id_inst   (if_id_inst),
        .if_id_pc2    (if_id_pc2),
        .if_id_valid  (if_id_valid),
        .halt_fetched (halt_fetched)
    );

    typedef struct {
        logic        ds;
        logic        re;
        logic [15:0] rpc;
        logic        ist;
        logic        done;
        logic [15:0] data;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] inst;
        logic [15:0] pc2;
        logic        v;
        logic        halt;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ds, input logic re, input logic [15:0] rpc,
                         input logic ist, input logic done, input logic [15:0] data);
        dec_stall    = ds;
        redirect_en  = re;
        redirect_pc  = rpc;
        icache_stall = ist;
        icache_done  = done;
        icache_data  = data;
    endtask

    task automatic check_regs(input int idx, input logic [15:0] inst, input logic [15:0] pc2,
                              input logic v, input logic halt, input logic [15:0] pc);
        chk("if_id_inst", idx, if_id_inst, inst);
        chk("if_id_pc2", idx, if_id_pc2, pc2);
        chk("if_id_valid", idx, {15'd0, if_id_valid}, {15'd0, v});
        chk("halt_fetched", idx, {15'd0, halt_fetched}, {15'd0, halt});
        chk("fetch_pc", idx, fetch_pc, pc);
    endtask

    initial begin
        //          ds    re    rpc       ist   done  data       rd    addr      inst      pc2       v     halt  pc
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4001, 1'b1, 16'h0000, 16'h4001, 16'h0002, 1'b1, 1'b0, 16'h0002};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4002, 1'b1, 16'h0002, 16'h4002, 16'h0004, 1'b1, 1'b0, 16'h0004};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4003, 1'b1, 16'h0004, 16'h4003, 16'h0006, 1'b1, 1'b0, 16'h0006};
        // HALT at 6, then spurious done ignored, then redirect out of HALTED
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0006, 16'h0000, 16'h0008, 1'b1, 1'b1, 16'h0006};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0800, 16'h0008, 1'b0, 1'b1, 16'h0006};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4444, 1'b0, 16'h0006, 16'h0800, 16'h0008, 1'b0, 1'b1, 16'h0006};
        vecs[6]  = '{1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0800, 16'h0008, 1'b0, 1'b0, 16'h0020};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4020, 1'b1, 16'h0020, 16'h4020, 16'h0022, 1'b1, 1'b0, 16'h0022};
        // redirect to 0 with cache stalled (no request outstanding), then miss of 3 cycles
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0022, 16'h0800, 16'h0022, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0800, 16'h0022, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0800, 16'h0022, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4100, 1'b0, 16'h0000, 16'h4100, 16'h0002, 1'b1, 1'b0, 16'h0002};
        // decode stall across a hit: buffered, then drained
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4102, 1'b1, 16'h0002, 16'h4100, 16'h0002, 1'b1, 1'b0, 16'h0004};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 16'h4100, 16'h0002, 1'b1, 1'b0, 16'h0004};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4aaa, 1'b0, 16'h0004, 16'h4100, 16'h0002, 1'b1, 1'b0, 16'h0004};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 16'h4100, 16'h0002, 1'b1, 1'b0, 16'h0004};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 16'h4102, 16'h0004, 1'b1, 1'b0, 16'h0004};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4104, 1'b1, 16'h0004, 16'h4104, 16'h0006, 1'b1, 1'b0, 16'h0006};
        // redirect while in WAIT: pending done discarded
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0, 16'h0006};
        vecs[19] = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0800, 16'h0006, 1'b0, 1'b0, 16'h0100};
        vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4666, 1'b0, 16'h0100, 16'h0800, 16'h0006, 1'b0, 1'b0, 16'h0100};
        vecs[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4200, 1'b1, 16'h0100, 16'h4200, 16'h0102, 1'b1, 1'b0, 16'h0102};
        // redirect with a request in flight this cycle, then PC wrap at FFFE
        vecs[22] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0102, 16'h0800, 16'h0102, 1'b0, 1'b0, 16'hFFFE};
        vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4777, 1'b0, 16'hFFFE, 16'h0800, 16'h0102, 1'b0, 1'b0, 16'hFFFE};
        vecs[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4300, 1'b1, 16'hFFFE, 16'h4300, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[25] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4301, 1'b1, 16'h0000, 16'h4301, 16'h0002, 1'b1, 1'b0, 16'h0002};
        // cache stall: no request, unsolicited done ignored
        vecs[26] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h0800, 16'h0002, 1'b0, 1'b0, 16'h0002};
        vecs[27] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4999, 1'b0, 16'h0002, 16'h0800, 16'h0002, 1'b0, 1'b0, 16'h0002};
        vecs[28] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4302, 1'b1, 16'h0002, 16'h4302, 16'h0004, 1'b1, 1'b0, 16'h0004};

        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset icache_rd", -1, {15'd0, icache_rd}, 16'd0);
        check_regs(-1, 16'h0800, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].ds, vecs[i].re, vecs[i].rpc, vecs[i].ist, vecs[i].done, vecs[i].data);
            @(negedge clk);
            chk("icache_rd", i, {15'd0, icache_rd}, {15'd0, vecs[i].rd});
            chk("icache_addr", i, icache_addr, vecs[i].addr);
            @(posedge clk);
            #1;
            check_regs(i, vecs[i].inst, vecs[i].pc2, vecs[i].v, vecs[i].halt, vecs[i].pc);
        end

        // Reset during WAIT: immediate reset values, late done ignored.
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("miss icache_rd", 100, {15'd0, icache_rd}, 16'd1);
        chk("miss icache_addr", 100, icache_addr, 16'h0004);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst icache_rd", 101, {15'd0, icache_rd}, 16'd0);
        check_regs(101, 16'h0800, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4abc);
        @(posedge clk);
        #1;
        check_regs(102, 16'h0800, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("post-rst icache_rd", 103, {15'd0, icache_rd}, 16'd1);
        chk("post-rst icache_addr", 103, icache_addr, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4001);
        @(posedge clk);
        #1;
        check_regs(104, 16'h4001, 16'h0002, 1'b1, 1'b0, 16'h0002);

        // HALT arriving under decode stall: buffered, PC held, HALTED on drain.
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005);
        @(posedge clk);
        #1;
        check_regs(105, 16'h4001, 16'h0002, 1'b1, 1'b0, 16'h0002);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        check_regs(106, 16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0002);
        @(negedge clk);
        chk("halted icache_rd", 107, {15'd0, icache_rd}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
